// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types, constants and helpers for the LCD image path.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // Default pixel depth shared by the loader and the image memory
    localparam int c_PIXEL_BIT_COUNT = 32;

    // Address width for a memory of mem_size pixels; never narrower than 1 bit
    function automatic int addr_size(input int mem_size);
        return (mem_size > 1) ? $clog2(mem_size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : image_loader_if
//  Description : Byte-stream input, memory-write output and status bundle of
//                the image loader. master = stream source / controller side,
//                slave = the loader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface image_loader_if #(
    parameter int ADDR_SIZE       = 14,
    parameter int PIXEL_BIT_COUNT = 32
);
    logic                       start;
    logic                       byte_valid;
    logic [7:0]                 byte_data;
    logic                       image_write_en;
    logic [ADDR_SIZE-1:0]       image_write_addr;
    logic [PIXEL_BIT_COUNT-1:0] image_write_data;
    logic                       busy;
    logic                       done;
    logic                       overflow;

    modport master (
        output start, byte_valid, byte_data,
        input  image_write_en, image_write_addr, image_write_data,
        input  busy, done, overflow
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output image_write_en, image_write_addr, image_write_data,
        output busy, done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/image_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Packs a byte stream big-endian into pixels. o_pixel and
//                o_pixel_valid are combinational in the cycle the final byte
//                of a pixel is accepted so the caller can register them with
//                a single cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer #(
    parameter int PIXEL_BIT_COUNT = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_clear,
    input  wire logic                       i_enable,
    input  wire logic                       i_byte_valid,
    input  wire logic [7:0]                 i_byte_data,
    output logic      [PIXEL_BIT_COUNT-1:0] o_pixel,
    output logic                            o_pixel_valid
);
    localparam int c_BPP   = PIXEL_BIT_COUNT / 8;
    localparam int c_CNT_W = (c_BPP > 1) ? $clog2(c_BPP) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BPP - 1);

    logic               w_accept;
    logic [c_CNT_W-1:0] r_byte_cnt;

    assign w_accept      = i_enable & i_byte_valid;
    assign o_pixel_valid = w_accept && (r_byte_cnt == c_LAST);

    // Byte position within the current pixel, wrapping after the last byte
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_byte_cnt <= (r_byte_cnt == c_LAST) ? '0 : r_byte_cnt + 1'b1;
        end
    end

    generate
        if (c_BPP > 1) begin : g_shift
            localparam int c_SH_W = PIXEL_BIT_COUNT - 8;
            logic [c_SH_W-1:0]          r_shift;
            logic [PIXEL_BIT_COUNT-1:0] w_next;

            // Earlier bytes sit above the incoming one, giving {b0,b1,...}
            assign w_next  = {r_shift, i_byte_data};
            assign o_pixel = w_next;

            // Keep the most recent BPP-1 bytes; older ones fall off the top
            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_shift <= '0;
                end else if (w_accept) begin
                    r_shift <= w_next[c_SH_W-1:0];
                end
            end
        end else begin : g_single
            assign o_pixel = i_byte_data;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : image_loader
//  Description : Packs an incoming byte stream into pixels and writes them to
//                the image memory at consecutive addresses, reporting
//                busy / done / overflow to the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_loader
    import lcd_pkg::*;
#(
    parameter  int MEM_WIDTH       = 100,
    parameter  int MEM_HEIGHT      = 100,
    parameter  int PIXEL_BIT_COUNT = c_PIXEL_BIT_COUNT,
    localparam int MEM_SIZE        = MEM_WIDTH * MEM_HEIGHT,
    localparam int ADDR_SIZE       = addr_size(MEM_SIZE)
) (
    input  wire logic     clk,
    input  wire logic     reset,
    image_loader_if.slave bus
);
    localparam logic [ADDR_SIZE-1:0] c_LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);

    generate
        if ((PIXEL_BIT_COUNT % 8 != 0) || (PIXEL_BIT_COUNT < 8)) begin : g_bad_pixel_width
            $error("image_loader: PIXEL_BIT_COUNT must be a non-zero multiple of 8");
        end
    endgenerate

    loader_state_t              r_state;
    logic [ADDR_SIZE-1:0]       r_addr_cnt;
    logic                       r_write_en;
    logic [ADDR_SIZE-1:0]       r_write_addr;
    logic [PIXEL_BIT_COUNT-1:0] r_write_data;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_overflow;

    logic                       w_pack_en;
    logic [PIXEL_BIT_COUNT-1:0] w_pixel;
    logic                       w_pixel_valid;

    // A byte coinciding with start is dropped: only LOAD without start feeds the packer
    assign w_pack_en = (r_state == LOAD) && !bus.start;

    byte_packer #(
        .PIXEL_BIT_COUNT (PIXEL_BIT_COUNT)
    ) u_byte_packer (
        .clk           (clk),
        .rst           (reset),
        .i_clear       (bus.start),
        .i_enable      (w_pack_en),
        .i_byte_valid  (bus.byte_valid),
        .i_byte_data   (bus.byte_data),
        .o_pixel       (w_pixel),
        .o_pixel_valid (w_pixel_valid)
    );

    // Load sequencer: state, address counter, write strobe and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr_cnt   <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            if (bus.start) begin
                r_state    <= LOAD;
                r_addr_cnt <= '0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    LOAD: begin
                        if (w_pixel_valid) begin
                            r_write_en   <= 1'b1;
                            r_write_addr <= r_addr_cnt;
                            r_write_data <= w_pixel;
                            if (r_addr_cnt == c_LAST_ADDR) begin
                                // Final pixel: counter parks here, no wrap
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_addr_cnt <= r_addr_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (bus.byte_valid) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    default: begin
                        // IDLE: stream is ignored until start
                    end
                endcase
            end
        end
    end

    assign bus.image_write_en   = r_write_en;
    assign bus.image_write_addr = r_write_addr;
    assign bus.image_write_data = r_write_data;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.overflow         = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_loader
//  Description : Scoreboard bench for image_loader: a 4x2 32-bit instance
//                and a 4x2 8-bit instance share clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_loader;
    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    image_loader_if #(.ADDR_SIZE(3), .PIXEL_BIT_COUNT(32)) ifa ();
    image_loader_if #(.ADDR_SIZE(3), .PIXEL_BIT_COUNT(8))  ifb ();

    image_loader #(.MEM_WIDTH(4), .MEM_HEIGHT(2), .PIXEL_BIT_COUNT(32)) u_dut_a (
        .clk (clk), .reset (rst), .bus (ifa)
    );
    image_loader #(.MEM_WIDTH(4), .MEM_HEIGHT(2), .PIXEL_BIT_COUNT(8)) u_dut_b (
        .clk (clk), .reset (rst), .bus (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write strobe must match the head of its scoreboard queue
    always @(negedge clk) begin
        if (ifa.image_write_en === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL wrA_unexpected: got addr=%0d data=%h cyc=%0d, required no write",
                         ifa.image_write_addr, ifa.image_write_data, cyc);
            end else begin
                ea = qa.pop_front();
                if (ifa.image_write_addr !== ea.addr || ifa.image_write_data !== ea.data || cyc != ea.cyc) begin
                    errors++;
                    $display("FAIL wrA: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             ifa.image_write_addr, ifa.image_write_data, cyc, ea.addr, ea.data, ea.cyc);
                end
            end
        end
        if (ifb.image_write_en === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL wrB_unexpected: got addr=%0d data=%h cyc=%0d, required no write",
                         ifb.image_write_addr, ifb.image_write_data, cyc);
            end else begin
                eb = qb.pop_front();
                if (ifb.image_write_addr !== eb.addr || {24'h0, ifb.image_write_data} !== eb.data || cyc != eb.cyc) begin
                    errors++;
                    $display("FAIL wrB: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             ifb.image_write_addr, ifb.image_write_data, cyc, eb.addr, eb.data, eb.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic start_a();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] b);
        ifa.byte_valid = 1'b1;
        ifa.byte_data  = b;
        tick();
        ifa.byte_valid = 1'b0;
    endtask

    // Expected write lands one cycle after the final byte is sampled
    task automatic push_a(input logic [2:0] addr, input logic [31:0] data);
        qa.push_back('{addr: addr, data: data, cyc: cyc + 1});
    endtask

    task automatic send_px_a(input logic [2:0] addr, input logic [31:0] px);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push_a(addr, px);
            send_a(px[31-8*i -: 8]);
        end
    endtask

    task automatic chk_all_zero_a(input string tag);
        chk({tag, "_en"},   {31'h0, ifa.image_write_en}, 32'h0);
        chk({tag, "_addr"}, {29'h0, ifa.image_write_addr}, 32'h0);
        chk({tag, "_data"}, ifa.image_write_data, 32'h0);
        chk({tag, "_busy"}, {31'h0, ifa.busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, ifa.done}, 32'h0);
        chk({tag, "_ovf"},  {31'h0, ifa.overflow}, 32'h0);
    endtask

    initial begin
        ifa.start = 1'b0; ifa.byte_valid = 1'b0; ifa.byte_data = 8'h00;
        ifb.start = 1'b0; ifb.byte_valid = 1'b0; ifb.byte_data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        chk_all_zero_a("reset");
        chk("reset_busyB", {31'h0, ifb.busy}, 32'h0);

        // Full image 0x00..0x1F back-to-back
        start_a();
        chk("start_busy", {31'h0, ifa.busy}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            send_px_a(3'(k), {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
        end
        chk("full_done", {31'h0, ifa.done}, 32'h1);
        chk("full_busy", {31'h0, ifa.busy}, 32'h0);
        chk("full_en_with_done", {31'h0, ifa.image_write_en}, 32'h1);

        // Gap inside a pixel
        start_a();
        send_a(8'hAA);
        send_a(8'hBB);
        repeat (3) tick();
        chk("gap_busy_mid", {31'h0, ifa.busy}, 32'h1);
        send_a(8'hCC);
        push_a(3'd0, 32'hAABBCCDD);
        send_a(8'hDD);
        chk("gap_busy_after", {31'h0, ifa.busy}, 32'h1);

        // Finish the image, then overflow in DONE
        for (int k = 1; k < 8; k++) begin
            send_px_a(3'(k), 32'hA0B0C000 | 32'(k));
        end
        chk("fill_done", {31'h0, ifa.done}, 32'h1);
        send_a(8'h55);
        chk("ovf_set", {31'h0, ifa.overflow}, 32'h1);
        tick();
        chk("ovf_sticky", {31'h0, ifa.overflow}, 32'h1);
        start_a();
        chk("ovf_clr", {31'h0, ifa.overflow}, 32'h0);
        chk("ovf_done_clr", {31'h0, ifa.done}, 32'h0);
        chk("ovf_busy", {31'h0, ifa.busy}, 32'h1);
        send_px_a(3'd0, 32'h10111213);

        // Restart mid-pixel with a coincident byte that must be dropped
        start_a();
        send_px_a(3'd0, 32'h20212223);
        send_a(8'h24);
        send_a(8'h25);
        ifa.start = 1'b1; ifa.byte_valid = 1'b1; ifa.byte_data = 8'h99;
        tick();
        ifa.start = 1'b0; ifa.byte_valid = 1'b0;
        send_px_a(3'd0, 32'h01020304);
        chk("restart_busy", {31'h0, ifa.busy}, 32'h1);

        // Reset mid-load, then bytes without start produce nothing
        start_a();
        for (int k = 0; k < 3; k++) begin
            send_px_a(3'(k), 32'h40414243 + 32'(k));
        end
        send_a(8'h50);
        send_a(8'h51);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero_a("midrst");
        for (int i = 0; i < 8; i++) send_a(8'h60 + 8'(i));
        chk("idle_busy", {31'h0, ifa.busy}, 32'h0);
        chk("idle_en", {31'h0, ifa.image_write_en}, 32'h0);

        // 8-bit pixels: a write every cycle
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            qb.push_back('{addr: 3'(i), data: 32'h30 + 32'(i), cyc: cyc + 1});
            ifb.byte_valid = 1'b1;
            ifb.byte_data  = 8'h30 + 8'(i);
            tick();
        end
        ifb.byte_valid = 1'b0;
        chk("b_done", {31'h0, ifb.done}, 32'h1);

        repeat (4) tick();
        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
